// File: rtl/tc_io_gpio_bank.sv
// GPIO bank: registers core controls onto tri_full pad cells, and synchronises,
// glitch-filters and edge-detects the pad inputs into per-pad pending interrupts.
module tc_io_gpio_bank #(
  parameter int NUM_PAD     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_PAD-1:0] out_i,
  input  logic [NUM_PAD-1:0] oe_i,
  input  logic [NUM_PAD-1:0] cs_i,
  input  logic [NUM_PAD-1:0] pu_i,
  input  logic [NUM_PAD-1:0] pd_i,
  input  logic [FILT_W-1:0]  filt_thr_i,
  input  logic [NUM_PAD-1:0] rise_en_i,
  input  logic [NUM_PAD-1:0] fall_en_i,
  input  logic [NUM_PAD-1:0] irq_clr_i,
  output logic [NUM_PAD-1:0] pad_c2p_o,
  output logic [NUM_PAD-1:0] pad_c2p_en_o,
  output logic [NUM_PAD-1:0] pad_cs_o,
  output logic [NUM_PAD-1:0] pad_pu_o,
  output logic [NUM_PAD-1:0] pad_pd_o,
  input  logic [NUM_PAD-1:0] pad_p2c_i,
  output logic [NUM_PAD-1:0] in_o,
  output logic [NUM_PAD-1:0] irq_pend_o,
  output logic               irq_o
);

  localparam logic [FILT_W:0]   CNT_ONE = (FILT_W + 1)'(1);
  localparam logic [FILT_W-1:0] CNT_INC = FILT_W'(1);

  logic [NUM_PAD-1:0] c2p_q, c2p_d, c2p_en_q, c2p_en_d, cs_q, cs_d;
  logic [NUM_PAD-1:0] pu_q, pu_d, pd_q, pd_d;
  logic [NUM_PAD-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PAD-1:0] sync_d [SYNC_STAGES];
  logic [NUM_PAD-1:0] filt_q, filt_d;
  logic [FILT_W-1:0]  cnt_q [NUM_PAD];
  logic [FILT_W-1:0]  cnt_d [NUM_PAD];
  logic [NUM_PAD-1:0] pend_q, pend_d;
  logic [NUM_PAD-1:0] sync_s, rise_set, fall_set;
  logic [FILT_W-1:0]  thr_eff;

  assign sync_s  = sync_q[SYNC_STAGES-1];
  // A zero threshold means "follow the synchroniser with one cycle of delay".
  assign thr_eff = (filt_thr_i == '0) ? CNT_INC : filt_thr_i;

  always_comb begin
    c2p_d    = out_i;
    c2p_en_d = oe_i;
    cs_d     = cs_i;
    pu_d     = pu_i;
    pd_d     = pd_i;
  end

  always_comb begin
    sync_d[0] = pad_p2c_i;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
  end

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NUM_PAD; i++) begin
      cnt_d[i] = '0;
      if (sync_s[i] != filt_q[i]) begin
        // Compare one bit wider so C+1 cannot wrap; a lowered threshold commits at once.
        if (({1'b0, cnt_q[i]} + CNT_ONE) >= {1'b0, thr_eff}) filt_d[i] = sync_s[i];
        else if (&cnt_q[i])                                   cnt_d[i]  = cnt_q[i];
        else                                                  cnt_d[i]  = cnt_q[i] + CNT_INC;
      end
    end
  end

  always_comb begin
    rise_set = filt_d & ~filt_q & rise_en_i;
    fall_set = ~filt_d & filt_q & fall_en_i;
    pend_d   = (pend_q & ~irq_clr_i) | rise_set | fall_set;
  end

  // NOTE: sequential state uses non-blocking assignments only, so flops update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      c2p_q    <= '0;
      c2p_en_q <= '0;
      cs_q     <= '1;
      pu_q     <= '0;
      pd_q     <= '0;
      // NOTE: these arrays are a handful of flops, not RAM, so they are reset element by element.
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < NUM_PAD; i++) cnt_q[i] <= '0;
      filt_q   <= '0;
      pend_q   <= '0;
    end else begin
      c2p_q    <= c2p_d;
      c2p_en_q <= c2p_en_d;
      cs_q     <= cs_d;
      pu_q     <= pu_d;
      pd_q     <= pd_d;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
      for (int i = 0; i < NUM_PAD; i++) cnt_q[i] <= cnt_d[i];
      filt_q   <= filt_d;
      pend_q   <= pend_d;
    end
  end

  assign pad_c2p_o    = c2p_q;
  assign pad_c2p_en_o = c2p_en_q;
  assign pad_cs_o     = cs_q;
  assign pad_pu_o     = pu_q & ~pd_q;
  assign pad_pd_o     = pd_q;
  assign in_o         = filt_q;
  assign irq_pend_o   = pend_q;
  assign irq_o        = |pend_q;

endmodule

// File: tb/tb_tc_io_gpio_bank.sv
// Directed bench for tc_io_gpio_bank: default instance plus a FILT_W=2 instance
// for the narrow-counter cases. Inputs change on negedge, outputs sampled on negedge.
module tb_tc_io_gpio_bank;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [7:0] out_i, oe_i, cs_i, pu_i, pd_i, rise_en_i, fall_en_i, irq_clr_i, pad_p2c_i;
  logic [3:0] filt_thr_i;
  logic [7:0] pad_c2p_o, pad_c2p_en_o, pad_cs_o, pad_pu_o, pad_pd_o, in_o, irq_pend_o;
  logic       irq_o;

  logic [7:0] pad_w2;
  logic [1:0] thr_w2;
  logic [7:0] c2p_w2, c2p_en_w2, cs_w2, pu_w2, pd_w2, in_w2, pend_w2;
  logic       irq_w2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  tc_io_gpio_bank dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .out_i(out_i), .oe_i(oe_i), .cs_i(cs_i),
    .pu_i(pu_i), .pd_i(pd_i), .filt_thr_i(filt_thr_i), .rise_en_i(rise_en_i),
    .fall_en_i(fall_en_i), .irq_clr_i(irq_clr_i), .pad_c2p_o(pad_c2p_o),
    .pad_c2p_en_o(pad_c2p_en_o), .pad_cs_o(pad_cs_o), .pad_pu_o(pad_pu_o),
    .pad_pd_o(pad_pd_o), .pad_p2c_i(pad_p2c_i), .in_o(in_o),
    .irq_pend_o(irq_pend_o), .irq_o(irq_o)
  );

  tc_io_gpio_bank #(.NUM_PAD(8), .SYNC_STAGES(2), .FILT_W(2)) dut_w2 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .out_i(out_i), .oe_i(oe_i), .cs_i(cs_i),
    .pu_i(pu_i), .pd_i(pd_i), .filt_thr_i(thr_w2), .rise_en_i(rise_en_i),
    .fall_en_i(fall_en_i), .irq_clr_i(irq_clr_i), .pad_c2p_o(c2p_w2),
    .pad_c2p_en_o(c2p_en_w2), .pad_cs_o(cs_w2), .pad_pu_o(pu_w2),
    .pad_pd_o(pd_w2), .pad_p2c_i(pad_w2), .in_o(in_w2),
    .irq_pend_o(pend_w2), .irq_o(irq_w2)
  );

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    out_i = 8'hFF; oe_i = 8'hFF; cs_i = 8'h00; pu_i = 8'hFF; pd_i = 8'hFF;
    pad_p2c_i = 8'hFF; pad_w2 = 8'hFF; filt_thr_i = 4'd0; thr_w2 = 2'd0;
    rise_en_i = 8'hFF; fall_en_i = 8'hFF; irq_clr_i = 8'h00;
    tick(); tick();
    n_checks++;
    if ({pad_c2p_o, pad_c2p_en_o, pad_pu_o, pad_pd_o} !== 32'h0) begin
      n_fail++; $display("FAIL reset_pad_regs: got %h expected %h", {pad_c2p_o, pad_c2p_en_o, pad_pu_o, pad_pd_o}, 32'h0);
    end
    n_checks++;
    if (pad_cs_o !== 8'hFF) begin
      n_fail++; $display("FAIL reset_cs: got %h expected %h", pad_cs_o, 8'hFF);
    end
    n_checks++;
    if ({in_o, irq_pend_o, irq_o} !== 17'h0) begin
      n_fail++; $display("FAIL reset_in_irq: got %h expected %h", {in_o, irq_pend_o, irq_o}, 17'h0);
    end
    n_checks++;
    if ({in_w2, pend_w2, irq_w2, cs_w2} !== {17'h0, 8'hFF}) begin
      n_fail++; $display("FAIL reset_w2: got %h expected %h", {in_w2, pend_w2, irq_w2, cs_w2}, {17'h0, 8'hFF});
    end
    out_i = 8'h00; oe_i = 8'h00; pu_i = 8'h00; pd_i = 8'h00;
    pad_p2c_i = 8'h00; pad_w2 = 8'h00; rise_en_i = 8'h00; fall_en_i = 8'h00;
    rst_n_i = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_pad_regs();
    oe_i = 8'hF0; out_i = 8'hA5; pu_i = 8'hFF; pd_i = 8'hFF; cs_i = 8'h3C;
    #1;
    n_checks++;
    if ({pad_c2p_en_o, pad_c2p_o, pad_cs_o} !== 24'h0) begin
      n_fail++; $display("FAIL pad_regs_latency: got %h expected %h", {pad_c2p_en_o, pad_c2p_o, pad_cs_o}, 24'h0);
    end
    tick();
    n_checks++;
    if ({pad_c2p_en_o, pad_c2p_o, pad_cs_o, pad_pu_o, pad_pd_o} !== 40'hF0_A5_3C_00_FF) begin
      n_fail++; $display("FAIL pad_regs_pd_wins: got %h expected %h", {pad_c2p_en_o, pad_c2p_o, pad_cs_o, pad_pu_o, pad_pd_o}, 40'hF0_A5_3C_00_FF);
    end
    n_checks++;
    if ({c2p_en_w2, c2p_w2, cs_w2, pu_w2, pd_w2} !== 40'hF0_A5_3C_00_FF) begin
      n_fail++; $display("FAIL pad_regs_w2: got %h expected %h", {c2p_en_w2, c2p_w2, cs_w2, pu_w2, pd_w2}, 40'hF0_A5_3C_00_FF);
    end
    pd_i = 8'h0F;
    tick();
    n_checks++;
    if ({pad_pu_o, pad_pd_o} !== 16'hF0_0F) begin
      n_fail++; $display("FAIL pad_regs_pu_pd: got %h expected %h", {pad_pu_o, pad_pd_o}, 16'hF0_0F);
    end
  endtask

  task automatic test_thr0_rise();
    filt_thr_i = 4'd0; rise_en_i = 8'h01;
    pad_p2c_i[0] = 1'b1;
    tick(); tick();
    n_checks++;
    if ({in_o, irq_pend_o} !== 16'h0) begin
      n_fail++; $display("FAIL thr0_before_e2: got %h expected %h", {in_o, irq_pend_o}, 16'h0);
    end
    tick();
    n_checks++;
    if ({in_o, irq_pend_o, irq_o} !== {8'h01, 8'h01, 1'b1}) begin
      n_fail++; $display("FAIL thr0_after_e2: got %h expected %h", {in_o, irq_pend_o, irq_o}, {8'h01, 8'h01, 1'b1});
    end
    irq_clr_i = 8'h01;
    tick();
    irq_clr_i = 8'h00;
    n_checks++;
    if ({irq_pend_o, irq_o} !== 9'h0) begin
      n_fail++; $display("FAIL thr0_clear: got %h expected %h", {irq_pend_o, irq_o}, 9'h0);
    end
    rise_en_i = 8'h00;
  endtask

  task automatic test_filter_pulse();
    logic exp;
    filt_thr_i = 4'd4;
    pad_p2c_i[3] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_checks++;
      if (in_o[3] !== 1'b0) begin
        n_fail++; $display("FAIL pulse3_cycle%0d: got %b expected %b", k, in_o[3], 1'b0);
      end
      if (k == 2) pad_p2c_i[3] = 1'b0;
    end
    pad_p2c_i[3] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      exp = (k >= 5 && k <= 8);
      n_checks++;
      if (in_o[3] !== exp) begin
        n_fail++; $display("FAIL pulse4_cycle%0d: got %b expected %b", k, in_o[3], exp);
      end
      if (k == 3) pad_p2c_i[3] = 1'b0;
    end
    n_checks++;
    if ({irq_pend_o, irq_o} !== 9'h0) begin
      n_fail++; $display("FAIL pulse_no_irq: got %h expected %h", {irq_pend_o, irq_o}, 9'h0);
    end
  endtask

  task automatic test_irq_clr_collision();
    filt_thr_i = 4'd0; rise_en_i = 8'h20; fall_en_i = 8'h20;
    pad_p2c_i[5] = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (irq_pend_o !== 8'h20) begin
      n_fail++; $display("FAIL collide_rise_set: got %h expected %h", irq_pend_o, 8'h20);
    end
    pad_p2c_i[5] = 1'b0;
    tick(); tick();
    n_checks++;
    if ({in_o[5], irq_pend_o} !== {1'b1, 8'h20}) begin
      n_fail++; $display("FAIL collide_pre_fall: got %h expected %h", {in_o[5], irq_pend_o}, {1'b1, 8'h20});
    end
    irq_clr_i = 8'h20;
    tick();
    irq_clr_i = 8'h00;
    n_checks++;
    if ({in_o[5], irq_pend_o, irq_o} !== {1'b0, 8'h20, 1'b1}) begin
      n_fail++; $display("FAIL collide_set_wins: got %h expected %h", {in_o[5], irq_pend_o, irq_o}, {1'b0, 8'h20, 1'b1});
    end
    rise_en_i = 8'h00; fall_en_i = 8'h00;
    tick();
    n_checks++;
    if (irq_pend_o !== 8'h20) begin
      n_fail++; $display("FAIL enable_drop_keeps: got %h expected %h", irq_pend_o, 8'h20);
    end
    irq_clr_i = 8'h20;
    tick();
    irq_clr_i = 8'h00;
    n_checks++;
    if ({irq_pend_o, irq_o} !== 9'h0) begin
      n_fail++; $display("FAIL clear_alone: got %h expected %h", {irq_pend_o, irq_o}, 9'h0);
    end
  endtask

  task automatic test_filt_w2();
    logic exp;
    thr_w2 = 2'd3;
    pad_w2[0] = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick();
      exp = (k >= 4);
      n_checks++;
      if (in_w2 !== {7'h0, exp}) begin
        n_fail++; $display("FAIL w2_hold_cycle%0d: got %h expected %h", k, in_w2, {7'h0, exp});
      end
    end
  endtask

  task automatic test_thr_drop();
    pad_w2[1] = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (in_w2 !== 8'h01) begin
      n_fail++; $display("FAIL thr_drop_counting: got %h expected %h", in_w2, 8'h01);
    end
    thr_w2 = 2'd1;
    tick();
    n_checks++;
    if (in_w2 !== 8'h03) begin
      n_fail++; $display("FAIL thr_drop_commit: got %h expected %h", in_w2, 8'h03);
    end
    thr_w2 = 2'd3;
  endtask

  task automatic test_reset_mid_count();
    filt_thr_i = 4'd4; rise_en_i = 8'h00;
    pad_p2c_i[2] = 1'b1;
    tick(); tick(); tick();
    #1 rst_n_i = 1'b0;
    #1;
    n_checks++;
    if ({pad_c2p_o, pad_c2p_en_o, pad_pu_o, pad_pd_o, pad_cs_o} !== {32'h0, 8'hFF}) begin
      n_fail++; $display("FAIL async_reset_pads: got %h expected %h", {pad_c2p_o, pad_c2p_en_o, pad_pu_o, pad_pd_o, pad_cs_o}, {32'h0, 8'hFF});
    end
    n_checks++;
    if ({in_o, irq_pend_o, irq_o, in_w2} !== 25'h0) begin
      n_fail++; $display("FAIL async_reset_in: got %h expected %h", {in_o, irq_pend_o, irq_o, in_w2}, 25'h0);
    end
    tick(); tick();
    filt_thr_i = 4'd0; rise_en_i = 8'h04;
    rst_n_i = 1'b1;
    tick(); tick();
    n_checks++;
    if ({in_o, irq_pend_o} !== 16'h0) begin
      n_fail++; $display("FAIL post_reset_settle: got %h expected %h", {in_o, irq_pend_o}, 16'h0);
    end
    tick();
    n_checks++;
    if ({in_o, irq_pend_o, irq_o} !== {8'h05, 8'h04, 1'b1}) begin
      n_fail++; $display("FAIL post_reset_rise: got %h expected %h", {in_o, irq_pend_o, irq_o}, {8'h05, 8'h04, 1'b1});
    end
    #1 rst_n_i = 1'b0;
    #1;
    n_checks++;
    if ({irq_pend_o, irq_o} !== 9'h0) begin
      n_fail++; $display("FAIL async_reset_pend: got %h expected %h", {irq_pend_o, irq_o}, 9'h0);
    end
    tick();
    rise_en_i = 8'h00;
    rst_n_i = 1'b1;
    tick(); tick(); tick(); tick();
    n_checks++;
    if ({in_o, irq_pend_o, irq_o} !== {8'h05, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL post_reset_no_irq: got %h expected %h", {in_o, irq_pend_o, irq_o}, {8'h05, 8'h00, 1'b0});
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_pad_regs();
    test_thr0_rise();
    test_filter_pulse();
    test_irq_clr_collision();
    test_filt_w2();
    test_thr_drop();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
